// File: rtl/registrador_deslocador_pkg.sv
// Shared definitions for the universal shift register: command codes,
// controller state encoding and a small command-classification helper.
package registrador_deslocador_pkg;

    typedef logic [1:0] modo_t;

    // Command codes, also used as the per-bit selection code of each cell
    localparam modo_t MODO_CARGA   = 2'b00;
    localparam modo_t MODO_ESQ_DIR = 2'b01;
    localparam modo_t MODO_DIR_ESQ = 2'b10;
    localparam modo_t MODO_NADA    = 2'b11;

    // Controller states
    localparam logic [1:0] OCIOSO     = 2'b00;
    localparam logic [1:0] DESLOCANDO = 2'b01;
    localparam logic [1:0] CONCLUIDO  = 2'b10;

    function automatic logic modo_desloca(input modo_t m);
        return (m == MODO_ESQ_DIR) || (m == MODO_DIR_ESQ);
    endfunction

endpackage

// File: rtl/celula_deslocamento.sv
// One storage bit of the shift register: a three-way source select
// (parallel value, left neighbour, right neighbour) feeding an enabled flop.
// Selection code 11 keeps the current value.
module celula_deslocamento
    import registrador_deslocador_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       habilita,
    input  logic [1:0] selecao,
    input  logic       d_paralelo,
    input  logic       d_esq,
    input  logic       d_dir,
    output logic       q
);

    logic d_prox;

    // Pick the source for the next value of this bit
    always_comb begin
        d_prox = q;
        case (selecao)
            MODO_CARGA:   d_prox = d_paralelo;
            MODO_ESQ_DIR: d_prox = d_esq;
            MODO_DIR_ESQ: d_prox = d_dir;
            default:      d_prox = q;
        endcase
    end

    // Storage flop, written only when the controller enables it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= 1'b0;
        end else if (habilita) begin
            q <= d_prox;
        end
    end

endmodule

// File: rtl/registrador_deslocador.sv
// Universal shift register with step-counting controller.
//
// state      | meaning
// OCIOSO     | waiting for iniciar; captures modo/passos/rotacionar
// DESLOCANDO | one shift per edge until the step counter reaches zero
// CONCLUIDO  | one-cycle completion pulse, then back to OCIOSO
module registrador_deslocador
    import registrador_deslocador_pkg::*;
#(
    parameter int LARGURA     = 8,
    parameter int BITS_PASSOS = $clog2(LARGURA) + 1
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   iniciar,
    input  logic [1:0]             modo,
    input  logic [BITS_PASSOS-1:0] passos,
    input  logic                   rotacionar,
    input  logic [LARGURA-1:0]     entrada_paralela,
    input  logic                   entrada_serial_esq,
    input  logic                   entrada_serial_dir,
    output logic [LARGURA-1:0]     saida,
    output logic                   saida_serial,
    output logic                   ocupado,
    output logic                   concluido
);

    logic [1:0]             estado;
    logic [1:0]             estado_prox;
    logic [BITS_PASSOS-1:0] contador;
    logic [1:0]             modo_reg;
    logic                   rot_reg;
    logic                   captura;
    logic                   ultimo_passo;
    logic [1:0]             sel_celulas;
    logic                   hab_celulas;
    logic                   fill_esq;
    logic                   fill_dir;
    logic                   bit_saindo;
    logic [LARGURA-1:0]     viz_esq;
    logic [LARGURA-1:0]     viz_dir;

    assign captura      = (estado == OCIOSO) && iniciar;
    assign ultimo_passo = (contador == BITS_PASSOS'(1));

    // Vacated end bits take either the live serial input or the bit leaving the other end
    assign fill_esq   = rot_reg ? saida[0]         : entrada_serial_esq;
    assign fill_dir   = rot_reg ? saida[LARGURA-1] : entrada_serial_dir;
    assign bit_saindo = (modo_reg == MODO_ESQ_DIR) ? saida[0] : saida[LARGURA-1];

    // Parallel load happens on the capture edge itself; shifts use the captured mode
    always_comb begin
        sel_celulas = MODO_NADA;
        hab_celulas = 1'b0;
        if (captura && (modo == MODO_CARGA)) begin
            sel_celulas = MODO_CARGA;
            hab_celulas = 1'b1;
        end else if (estado == DESLOCANDO) begin
            sel_celulas = modo_reg;
            hab_celulas = 1'b1;
        end
    end

    genvar i;
    generate
        for (i = 0; i < LARGURA; i++) begin : g_bits
            if (i == LARGURA - 1) begin : g_msb
                assign viz_esq[i] = fill_esq;
            end else begin : g_meio_esq
                assign viz_esq[i] = saida[i+1];
            end

            if (i == 0) begin : g_lsb
                assign viz_dir[i] = fill_dir;
            end else begin : g_meio_dir
                assign viz_dir[i] = saida[i-1];
            end

            celula_deslocamento u_celula (
                .clk        (clk),
                .reset      (reset),
                .habilita   (hab_celulas),
                .selecao    (sel_celulas),
                .d_paralelo (entrada_paralela[i]),
                .d_esq      (viz_esq[i]),
                .d_dir      (viz_dir[i]),
                .q          (saida[i])
            );
        end
    endgenerate

    // Next-state logic; a zero-step shift or no-op goes straight to completion
    always_comb begin
        estado_prox = estado;
        case (estado)
            OCIOSO: begin
                if (iniciar) begin
                    if (modo_desloca(modo) && (passos != '0)) begin
                        estado_prox = DESLOCANDO;
                    end else begin
                        estado_prox = CONCLUIDO;
                    end
                end
            end
            DESLOCANDO: begin
                if (ultimo_passo) begin
                    estado_prox = CONCLUIDO;
                end
            end
            CONCLUIDO: estado_prox = OCIOSO;
            default:   estado_prox = OCIOSO;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_prox;
        end
    end

    // Command capture and step down-counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            contador <= '0;
            modo_reg <= MODO_CARGA;
            rot_reg  <= 1'b0;
        end else if (captura) begin
            modo_reg <= modo;
            rot_reg  <= rotacionar;
            if (modo_desloca(modo)) begin
                contador <= passos;
            end
        end else if (estado == DESLOCANDO) begin
            contador <= contador - BITS_PASSOS'(1);
        end
    end

    // Serial output keeps the bit shifted out on the most recent shift edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            saida_serial <= 1'b0;
        end else if (estado == DESLOCANDO) begin
            saida_serial <= bit_saindo;
        end
    end

    assign ocupado   = (estado == DESLOCANDO) || (estado == CONCLUIDO);
    assign concluido = (estado == CONCLUIDO);

endmodule

// File: tb/tb_registrador_deslocador.sv
// Directed bench for registrador_deslocador with hand-computed expectations.
module tb_registrador_deslocador;

    logic       clk;
    logic       reset;
    logic       iniciar;
    logic [1:0] modo;
    logic [3:0] passos;
    logic       rotacionar;
    logic [7:0] entrada_paralela;
    logic       entrada_serial_esq;
    logic       entrada_serial_dir;
    logic [7:0] saida;
    logic       saida_serial;
    logic       ocupado;
    logic       concluido;

    int total = 0;
    int bad   = 0;

    registrador_deslocador #(.LARGURA(8), .BITS_PASSOS(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .iniciar            (iniciar),
        .modo               (modo),
        .passos             (passos),
        .rotacionar         (rotacionar),
        .entrada_paralela   (entrada_paralela),
        .entrada_serial_esq (entrada_serial_esq),
        .entrada_serial_dir (entrada_serial_dir),
        .saida              (saida),
        .saida_serial       (saida_serial),
        .ocupado            (ocupado),
        .concluido          (concluido)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        total++;
        if (obs !== esp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
        end
    endtask

    // Issue one command; returns 1 ns after the capture edge
    task automatic comando(input logic [1:0] m, input logic [3:0] p, input logic r, input logic [7:0] par);
        @(negedge clk);
        modo             = m;
        passos           = p;
        rotacionar       = r;
        entrada_paralela = par;
        iniciar          = 1'b1;
        @(posedge clk);
        #1;
        iniciar = 1'b0;
    endtask

    // Edges after the capture edge until concluido is seen (bounded)
    task automatic espera_fim(output int n);
        n = 0;
        while (!concluido && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic proximo_ciclo;
        @(posedge clk);
        #1;
    endtask

    int n;
    int pulsos;
    int ocup;

    initial begin
        reset              = 1'b1;
        iniciar            = 1'b0;
        modo               = 2'b11;
        passos             = '0;
        rotacionar         = 1'b0;
        entrada_paralela   = '0;
        entrada_serial_esq = 1'b0;
        entrada_serial_dir = 1'b0;

        #12;
        verifica("rst_saida", saida, 8'h00);
        verifica("rst_serial", saida_serial, 1'b0);
        verifica("rst_ocupado", ocupado, 1'b0);
        verifica("rst_concluido", concluido, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Parallel load
        comando(2'b00, 4'd0, 1'b0, 8'hA5);
        verifica("carga_saida", saida, 8'hA5);
        verifica("carga_concluido", concluido, 1'b1);
        verifica("carga_ocupado", ocupado, 1'b1);
        proximo_ciclo();
        verifica("carga_concluido_fim", concluido, 1'b0);
        verifica("carga_ocupado_fim", ocupado, 1'b0);

        // Left-to-right by 3 with fill 1: A5 -> D2 -> E9 -> F4
        entrada_serial_esq = 1'b1;
        comando(2'b01, 4'd3, 1'b0, 8'h00);
        verifica("ed_ocupado_captura", ocupado, 1'b1);
        verifica("ed_saida_captura", saida, 8'hA5);
        proximo_ciclo();
        verifica("ed_passo1", saida, 8'hD2);
        verifica("ed_serial1", saida_serial, 1'b1);
        proximo_ciclo();
        verifica("ed_passo2", saida, 8'hE9);
        verifica("ed_serial2", saida_serial, 1'b0);
        espera_fim(n);
        verifica("ed_latencia", n, 1);
        verifica("ed_saida", saida, 8'hF4);
        verifica("ed_serial", saida_serial, 1'b1);
        proximo_ciclo();
        verifica("ed_ocupado_fim", ocupado, 1'b0);
        entrada_serial_esq = 1'b0;

        // Right-to-left by 2 with fill 0: F4 -> E8 -> D0
        entrada_serial_dir = 1'b0;
        comando(2'b10, 4'd2, 1'b0, 8'h00);
        espera_fim(n);
        verifica("de_latencia", n, 2);
        verifica("de_saida", saida, 8'hD0);
        verifica("de_serial", saida_serial, 1'b1);
        proximo_ciclo();

        // Right-to-left rotate by 1: 81 -> 03
        comando(2'b00, 4'd0, 1'b0, 8'h81);
        proximo_ciclo();
        entrada_serial_dir = 1'b0;
        comando(2'b10, 4'd1, 1'b1, 8'h00);
        espera_fim(n);
        verifica("rot1_latencia", n, 1);
        verifica("rot1_saida", saida, 8'h03);
        verifica("rot1_serial", saida_serial, 1'b1);
        proximo_ciclo();

        // Rotate by the full width restores the word
        comando(2'b00, 4'd0, 1'b0, 8'h81);
        proximo_ciclo();
        comando(2'b10, 4'd8, 1'b1, 8'h00);
        espera_fim(n);
        verifica("rot8_latencia", n, 8);
        verifica("rot8_saida", saida, 8'h81);
        verifica("rot8_serial", saida_serial, 1'b1);
        proximo_ciclo();

        // Left-to-right rotate by 3: 81 -> 30, last bit out 0
        comando(2'b01, 4'd3, 1'b1, 8'h00);
        espera_fim(n);
        verifica("rotd_saida", saida, 8'h30);
        verifica("rotd_serial", saida_serial, 1'b0);
        proximo_ciclo();

        // Ten steps on an 8-bit word with fill 0 empties it
        comando(2'b00, 4'd0, 1'b0, 8'hA5);
        proximo_ciclo();
        comando(2'b01, 4'd10, 1'b0, 8'h00);
        espera_fim(n);
        verifica("p10_latencia", n, 10);
        verifica("p10_saida", saida, 8'h00);
        verifica("p10_serial", saida_serial, 1'b0);
        proximo_ciclo();

        // Zero steps: no change, immediate completion, serial untouched
        comando(2'b00, 4'd0, 1'b0, 8'h5A);
        proximo_ciclo();
        comando(2'b01, 4'd0, 1'b0, 8'hFF);
        verifica("p0_concluido", concluido, 1'b1);
        verifica("p0_saida", saida, 8'h5A);
        verifica("p0_serial", saida_serial, 1'b0);
        proximo_ciclo();
        verifica("p0_concluido_fim", concluido, 1'b0);

        // No-op command
        comando(2'b11, 4'd5, 1'b1, 8'hFF);
        verifica("nada_concluido", concluido, 1'b1);
        verifica("nada_saida", saida, 8'h5A);
        proximo_ciclo();
        verifica("nada_ocupado_fim", ocupado, 1'b0);

        // iniciar during a shift is ignored: F0 shifted 4 times -> 0F
        comando(2'b00, 4'd0, 1'b0, 8'hF0);
        proximo_ciclo();
        comando(2'b01, 4'd4, 1'b0, 8'h00);
        @(negedge clk);
        modo             = 2'b00;
        entrada_paralela = 8'hFF;
        passos           = 4'd1;
        iniciar          = 1'b1;
        @(posedge clk);
        #1;
        iniciar = 1'b0;
        verifica("ign_passo1", saida, 8'h78);
        verifica("ign_ocupado", ocupado, 1'b1);
        espera_fim(n);
        verifica("ign_latencia", n, 3);
        verifica("ign_saida", saida, 8'h0F);
        proximo_ciclo();

        // Reset during the second shift of a five-step shift
        comando(2'b00, 4'd0, 1'b0, 8'hFF);
        proximo_ciclo();
        comando(2'b01, 4'd5, 1'b0, 8'h00);
        proximo_ciclo();
        verifica("rm_passo1", saida, 8'h7F);
        #2;
        reset = 1'b1;
        #1;
        verifica("rm_saida", saida, 8'h00);
        verifica("rm_ocupado", ocupado, 1'b0);
        verifica("rm_concluido", concluido, 1'b0);
        verifica("rm_serial", saida_serial, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        pulsos = 0;
        ocup   = 0;
        for (int k = 0; k < 8; k++) begin
            proximo_ciclo();
            if (concluido) pulsos++;
            if (ocupado) ocup++;
        end
        verifica("rm_sem_pulso", pulsos, 0);
        verifica("rm_sem_ocupado", ocup, 0);
        comando(2'b00, 4'd0, 1'b0, 8'h3C);
        verifica("rm_carga", saida, 8'h3C);
        verifica("rm_carga_concluido", concluido, 1'b1);
        proximo_ciclo();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
